// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// Execution unit driven by the 4-bit ALU control code. Single-cycle operations
// (ADD, SUB, AND, OR, SLT, SRA, SRAV) register their result on the acceptance
// edge. MUL runs on an iterative shift-add multiplier, one multiplier bit per
// cycle, LSB first. Unsupported codes return 0 with an err_o pulse.
//
// Configuration macro:
//   ALU_MUL_EARLY_EN - when defined, MUL also finishes as soon as the remaining
//                      multiplier bits are all zero. The result is unchanged.
//                      When undefined, MUL always takes exactly WIDTH cycles.
//
// Ports:
//   clk_i      in   clock, rising edge
//   rst_i      in   asynchronous, active-high reset
//   valid_i    in   request valid; accepted when valid_i && ready_o
//   ready_o    out  unit idle and able to accept a request
//   ALUCtrl_i  in   [3:0] operation code
//   src1_i     in   [WIDTH-1:0] operand 1 / MUL multiplicand / SRAV amount
//   src2_i     in   [WIDTH-1:0] operand 2 / MUL multiplier / shifted value
//   shamt_i    in   [SHAMT_W-1:0] immediate shift amount for SRA
//   result_o   out  [WIDTH-1:0] registered result, held between completions
//   zero_o     out  registered (result_o == 0)
//   done_o     out  one-cycle pulse: result_o/zero_o were just updated
//   err_o      out  one-cycle pulse with done_o for an unsupported code
// -----------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [3:0]         ALUCtrl_i,
  input  logic [WIDTH-1:0]   src1_i,
  input  logic [WIDTH-1:0]   src2_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [WIDTH-1:0]   result_o,
  output logic               zero_o,
  output logic               done_o,
  output logic               err_o
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SRAV = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  // Counter is one bit wider than SHAMT_W so it can represent WIDTH iterations.
  localparam logic [SHAMT_W:0] CNT_LAST = (SHAMT_W + 1)'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t             state, state_nxt;
  logic               accept;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_err;

  // Iterative multiplier datapath
  logic [WIDTH-1:0]   mcand, mplier, acc;
  logic [SHAMT_W:0]   cnt;
  logic [WIDTH-1:0]   acc_step, mplier_step;
  logic               mul_last;

  assign ready_o = (state == S_IDLE);
  assign accept  = valid_i && ready_o;

  // Single-cycle operation result.
  // NOTE: every variable driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (ALUCtrl_i)
      OP_AND:  alu_res = src1_i & src2_i;
      OP_OR:   alu_res = src1_i | src2_i;
      OP_ADD:  alu_res = src1_i + src2_i;
      OP_SUB:  alu_res = src1_i - src2_i;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      OP_SRA:  alu_res = $unsigned($signed(src2_i) >>> shamt_i);
      OP_SRAV: alu_res = $unsigned($signed(src2_i) >>> src1_i[SHAMT_W-1:0]);
      OP_MUL:  alu_res = '0;  // handled by the iterative multiplier
      default: alu_err = 1'b1;
    endcase
  end

  // One shift-add step; the result of the final step is what gets published.
  always_comb begin
    acc_step    = mplier[0] ? (acc + mcand) : acc;
    mplier_step = mplier >> 1;
`ifdef ALU_MUL_EARLY_EN
    mul_last    = (cnt == CNT_LAST) || (mplier_step == '0);
`else
    mul_last    = (cnt == CNT_LAST);
`endif
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && (ALUCtrl_i == OP_MUL)) state_nxt = S_MUL;
      S_MUL:  if (mul_last)                        state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: the multiplier registers are reset along with the outputs so an
  // aborted MUL leaves no stale partial product behind.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_o <= '0;
      zero_o   <= 1'b1;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      if (state == S_IDLE) begin
        if (accept) begin
          if (ALUCtrl_i == OP_MUL) begin
            mcand  <= src1_i;
            mplier <= src2_i;
            acc    <= '0;
            cnt    <= '0;
          end else begin
            result_o <= alu_res;
            zero_o   <= (alu_res == '0);
            done_o   <= 1'b1;
            err_o    <= alu_err;
          end
        end
      end else begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier_step;
        cnt    <= cnt + 1'b1;
        if (mul_last) begin
          result_o <= acc_step;
          zero_o   <= (acc_step == '0);
          done_o   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Directed-vector bench for alu_exec_unit. The stimulus process pushes the
// hand-computed expected response for every issued request into a queue; an
// independent monitor pops and compares each time done_o is seen.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SRAV = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1011;

`ifdef ALU_MUL_EARLY_EN
  localparam int BUSY_MUL5 = 3;   // src2 = 5: highest set bit 2
  localparam int BUSY_MUL0 = 1;   // src2 = 0
`else
  localparam int BUSY_MUL5 = 32;
  localparam int BUSY_MUL0 = 32;
`endif
  localparam int BUSY_MULF = 32;  // src2 MSB set: full length either way

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               valid_i;
  logic               ready_o;
  logic [3:0]         ALUCtrl_i;
  logic [WIDTH-1:0]   src1_i, src2_i;
  logic [SHAMT_W-1:0] shamt_i;
  logic [WIDTH-1:0]   result_o;
  logic               zero_o, done_o, err_o;

  alu_exec_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .ALUCtrl_i (ALUCtrl_i),
    .src1_i    (src1_i),
    .src2_i    (src2_i),
    .shamt_i   (shamt_i),
    .result_o  (result_o),
    .zero_o    (zero_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             err;
    string            name;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Issue one request (caller is just after a rising edge); returns just after
  // the acceptance edge with valid_i dropped, so back-to-back calls stay packed.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] res, input logic err,
                       input string name);
    check({name, "_ready"}, 32'(ready_o), 32'd1);
    valid_i   = 1'b1;
    ALUCtrl_i = op;
    src1_i    = a;
    src2_i    = b;
    shamt_i   = sh;
    exp_q.push_back('{res: res, err: err, name: name});
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  // Count busy cycles after a MUL acceptance while pressing an ADD request
  // that must be ignored (an accepted one would show up as an extra done_o).
  task automatic wait_mul(input string name, input int busy_exp);
    int busy;
    busy      = 0;
    valid_i   = 1'b1;
    ALUCtrl_i = OP_ADD;
    src1_i    = 32'h11;
    src2_i    = 32'h22;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (ready_o) break;
      busy++;
    end
    valid_i = 1'b0;
    check({name, "_busy_cycles"}, 32'(busy), 32'(busy_exp));
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: compare every completion against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (err_o && !done_o) check("err_without_done", 32'(err_o), 32'd0);
      if (done_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_result"}, result_o, e.res);
          check({e.name, "_zero"}, 32'(zero_o), 32'(e.res == '0));
          check({e.name, "_err"}, 32'(err_o), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i     = 1'b1;
    valid_i   = 1'b0;
    ALUCtrl_i = '0;
    src1_i    = '0;
    src2_i    = '0;
    shamt_i   = '0;
    repeat (3) @(negedge clk_i);
    check("rst_result", result_o, 32'd0);
    check("rst_zero",   32'(zero_o),  32'd1);
    check("rst_done",   32'(done_o),  32'd0);
    check("rst_err",    32'(err_o),   32'd0);
    check("rst_ready",  32'(ready_o), 32'd1);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // ADD with latency 1
    issue(OP_ADD, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0, "add_5_7");
    @(negedge clk_i);
    check("add_5_7_latency", 32'(done_o), 32'd1);
    @(posedge clk_i);
    #1;

    // Back-to-back: SUB 3-3 then signed SLT -1 < 1
    issue(OP_SUB,  32'd3,        32'd3,        5'd0, 32'd0,        1'b0, "sub_3_3");
    issue(OP_SLT,  32'hFFFFFFFF, 32'd1,        5'd0, 32'd1,        1'b0, "slt_m1_1");
    issue(OP_SLT,  32'd1,        32'hFFFFFFFF, 5'd0, 32'd0,        1'b0, "slt_1_m1");
    issue(OP_ADD,  32'hFFFFFFFF, 32'd2,        5'd0, 32'd1,        1'b0, "add_wrap");
    issue(OP_SUB,  32'd0,        32'd1,        5'd0, 32'hFFFFFFFF, 1'b0, "sub_wrap");
    issue(OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h00F000F0, 1'b0, "and");
    issue(OP_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'hFFF0FFF0, 1'b0, "or");
    issue(OP_SRA,  32'd0,        32'h80000000, 5'd4, 32'hF8000000, 1'b0, "sra_4");
    issue(OP_SRAV, 32'h24,       32'h80000000, 5'd0, 32'hF8000000, 1'b0, "srav_24");
    issue(OP_SRA,  32'd0,        32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, "sra_31");
    issue(OP_SRA,  32'd0,        32'h70000000, 5'd28, 32'h00000007, 1'b0, "sra_pos");
    issue(OP_ADD,  32'd9,        32'd1,        5'd0, 32'd10,       1'b0, "add_9_1");
    issue(4'b1111, 32'd9,        32'd1,        5'd0, 32'd0,        1'b1, "bad_1111");
    issue(4'b0011, 32'd9,        32'd1,        5'd0, 32'd0,        1'b1, "bad_0011");

    // Multiplier
    issue(OP_MUL, 32'h00010003, 32'h00000005, 5'd0, 32'h0005000F, 1'b0, "mul_5");
    wait_mul("mul_5", BUSY_MUL5);
    issue(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h00000001, 1'b0, "mul_ff");
    wait_mul("mul_ff", BUSY_MULF);
    issue(OP_MUL, 32'h12345678, 32'h00000000, 5'd0, 32'h00000000, 1'b0, "mul_0");
    wait_mul("mul_0", BUSY_MUL0);
    issue(OP_MUL, 32'h00000003, 32'h00000007, 5'd0, 32'h00000015, 1'b0, "mul_3_7");
    wait_mul("mul_3_7",
`ifdef ALU_MUL_EARLY_EN
             3
`else
             32
`endif
    );

    // Reset 10 cycles into a MUL: aborted, no completion expected.
    issue(OP_MUL, 32'h12345678, 32'h80000001, 5'd0, 32'd0, 1'b0, "mul_abort");
    repeat (10) @(negedge clk_i);
    check("mul_abort_busy", 32'(ready_o), 32'd0);
    void'(exp_q.pop_back());
    rst_i = 1'b1;
    #1;
    check("abort_result", result_o, 32'd0);
    check("abort_zero",   32'(zero_o),  32'd1);
    check("abort_done",   32'(done_o),  32'd0);
    check("abort_ready",  32'(ready_o), 32'd1);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    issue(OP_ADD, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0, "add_after_rst");
    @(negedge clk_i);
    check("add_after_rst_latency", 32'(done_o), 32'd1);

    repeat (5) @(negedge clk_i);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
